maze_store: RTL and testbench
=============================

MAZE_STORE -- requirements
Module: maze_store

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of the step counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load_valid  input  1  loader offers one cell.
REQ-005 SHALL have port load_data  input  1  offered cell: 1 = wall, 0 = corridor.
REQ-006 SHALL have port load_ready  output  1  store accepts a cell this cycle.
REQ-007 SHALL have port maze_ready  output  1  maze fully loaded; the solver may run.
REQ-008 SHALL have port row, col  input  6 each  cell address from the solver.
REQ-009 SHALL have port maze_oe  input  1  synchronous read strobe from the solver.
REQ-010 SHALL have port maze_we  input  1  synchronous mark-visited strobe from the solver.
REQ-011 SHALL have port maze_in  output  1  registered wall bit returned to the solver.
REQ-012 SHALL have port done  input  1  solver exit-found flag.
REQ-013 SHALL have port rd_row, rd_col  input  6 each  post-run readback address.
REQ-014 SHALL have port rd_cell  output  2  readback cell code.
REQ-015 SHALL have port steps  output  STEP_W  count of accepted marks.
REQ-016 SHALL have port visited  output  13  count of distinct cells marked.
REQ-017 SHALL have port wr_err  output  1  sticky flag: a mark was attempted on a wall cell.

Function
REQ-018 SHALL store 64x64 cells with 2-bit codes: FREE=0, WALL=1, VISITED=2; code 3 is never written.
REQ-019 SHALL implement the FSM LOAD -> RUN -> FINISHED; FINISHED is terminal until reset.
REQ-020 In LOAD, SHALL hold load_ready=1 and write each cell for which load_valid&&load_ready, in row-major order (row 0 col 0 first), using a 12-bit index.
REQ-021 SHALL, when cell index 4095 is accepted, go to RUN on the same edge, drop load_ready, and raise maze_ready on the next cycle.
REQ-022 In RUN, on an edge with maze_oe=1, SHALL load maze_in with (cell[row][col]==WALL); VISITED reads as 0.
REQ-023 SHALL hold maze_in between reads; the solver samples it two cycles after the strobe.
REQ-024 In RUN, on an edge with maze_we=1, SHALL change a FREE cell to VISITED, increment visited, and increment steps.
REQ-025 SHALL, on maze_we to a VISITED cell, leave the cell unchanged, increment steps only, and not increment visited.
REQ-026 SHALL, on maze_we to a WALL cell, leave the cell unchanged, set wr_err, and not increment steps.
REQ-027 SHALL saturate steps at all-ones and never wrap.
REQ-028 SHALL, when maze_oe and maze_we are both high on one edge, perform the write and load maze_in from the pre-write contents.
REQ-029 SHALL ignore maze_oe and maze_we in LOAD and FINISHED; maze_in SHALL stay 1 in LOAD.
REQ-030 SHALL, on an edge in RUN with done=1, go to FINISHED, still applying any maze_we on that same edge.
REQ-031 In FINISHED, SHALL register rd_cell from cell[rd_row][rd_col] (1-cycle latency); in other states rd_cell SHALL be 0.
REQ-032 SHALL keep maze_ready high in RUN and FINISHED.

Reset
REQ-033 Asserting rst SHALL force the following immediately: state=LOAD, load index=0, load_ready=1, maze_ready=0, maze_in=1, rd_cell=0, steps=0, visited=0, wr_err=0.
REQ-034 SHALL leave the cell array contents uncleared by reset; the following LOAD overwrites every cell.
REQ-035 SHALL, on reset mid-LOAD, discard the partial load and restart at index 0.

Structure
REQ-036 SHALL take the cell codes (FREE/WALL/VISITED) and FSM state encodings from shared package maze_pkg.
REQ-037 SHALL instantiate one sub-module, maze_cell_ram: 4096x2, one synchronous write port, two synchronous read ports (solver read and readback).

Verification
REQ-038 SHALL cover: load 4096 cells, all corridor except wall at (5,7); then oe at (5,7) -> maze_in=1 two cycles later; oe at (5,8) -> maze_in=0.
REQ-039 SHALL cover: we at (10,10) twice -> steps=2, visited=1; the readback after done gives rd_cell=2.
REQ-040 SHALL cover: we at the wall cell (5,7) -> wr_err=1, steps unchanged, rd_cell(5,7)=1.
REQ-041 SHALL cover: oe and we together at a FREE cell (3,3) -> maze_in=0, then cell code=2.
REQ-042 SHALL cover: rst asserted after 2000 loaded cells -> load_ready=1, maze_ready=0; a full reload then succeeds.
REQ-043 SHALL cover: STEP_W=4, 20 marks on one cell -> steps=15.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared cell codes, FSM state encodings and address helper for
//               the maze store. Cells are addressed {row, col} on a 64x64 grid.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

    localparam int unsigned c_dim_w  = 6;
    localparam int unsigned c_addr_w = 12;

    localparam logic [c_addr_w-1:0] c_last_idx = 12'hFFF;

    // Cell codes; code 3 is never written.
    localparam logic [1:0] c_cell_free    = 2'd0;
    localparam logic [1:0] c_cell_wall    = 2'd1;
    localparam logic [1:0] c_cell_visited = 2'd2;

    // FSM state encodings
    localparam logic [1:0] c_st_load     = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_finished = 2'd2;

    // Row-major flat index: row 0 col 0 is index 0, row 0 col 63 is index 63.
    function automatic logic [c_addr_w-1:0] cell_addr(
        input logic [c_dim_w-1:0] row,
        input logic [c_dim_w-1:0] col
    );
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_cell_ram.sv
`default_nettype none
// ============================================================================
// Module      : maze_cell_ram
// Description : Cell storage. One synchronous write port, two synchronous
//               read ports (A: solver, B: readback). Reads return the
//               contents from before a same-edge write. No reset: contents
//               are fully rewritten by every load.
// Ports       : clk                       - clock
//               i_we/i_waddr/i_wdata      - write port
//               i_a_en/i_a_addr/o_a_q     - enabled read port A
//               i_b_addr/o_b_q            - free-running read port B
// Revision    : 1.0 - initial release
// ============================================================================
module maze_cell_ram
    import maze_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_a_en,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [DATA_W-1:0] o_a_q,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [DATA_W-1:0] o_b_q
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_a_en) begin
            r_a_q <= r_mem[i_a_addr];
        end
        r_b_q <= r_mem[i_b_addr];
    end

    assign o_a_q = r_a_q;
    assign o_b_q = r_b_q;

endmodule
`default_nettype wire

// File: rtl/maze_store.sv
`default_nettype none
// ============================================================================
// Module      : maze_store
// Description : 64x64 maze cell store for a maze solver. Loads the maze
//               row-major from a valid/ready loader, then serves solver reads
//               (wall bit) and mark-visited writes with step/visited counting,
//               then offers a post-run readback once the solver is done.
// Ports       : clk, rst (async, active-high)
//               load_valid/load_data/load_ready  - loader handshake
//               maze_ready                       - load complete
//               row/col/maze_oe/maze_we/maze_in  - solver port
//               done                             - solver finished
//               rd_row/rd_col/rd_cell            - readback port
//               steps/visited/wr_err             - run statistics
// Revision    : 1.0 - initial release
// ============================================================================
module maze_store
    import maze_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic              load_data,
    output logic              load_ready,
    output logic              maze_ready,
    input  logic [5:0]        row,
    input  logic [5:0]        col,
    input  logic              maze_oe,
    input  logic              maze_we,
    output logic              maze_in,
    input  logic              done,
    input  logic [5:0]        rd_row,
    input  logic [5:0]        rd_col,
    output logic [1:0]        rd_cell,
    output logic [STEP_W-1:0] steps,
    output logic [12:0]       visited,
    output logic              wr_err
);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_in_load;
    logic       w_in_run;
    logic       w_in_fin;

    logic [c_addr_w-1:0] r_load_idx;
    logic                w_load_acc;
    logic                w_load_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_load:     if (w_load_last) w_state_nxt = c_st_run;
            c_st_run:      if (done)        w_state_nxt = c_st_finished;
            c_st_finished: w_state_nxt = c_st_finished;
            default:       w_state_nxt = c_st_load;
        endcase
    end

    always_comb begin
        w_in_load  = (r_state == c_st_load);
        w_in_run   = (r_state == c_st_run);
        w_in_fin   = (r_state == c_st_finished);
        load_ready = w_in_load;
        maze_ready = w_in_run | w_in_fin;
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    assign w_load_acc  = w_in_load & load_valid;
    assign w_load_last = w_load_acc && (r_load_idx == c_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_idx <= '0;
        end else if (w_load_acc) begin
            r_load_idx <= r_load_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Solver access pipeline.
    // The RAM reads synchronously, so an access strobed on edge k reads the
    // cell on edge k and is resolved on edge k+1 (write commit, counters,
    // maze_in). A mark committed on the same edge that the next access to
    // the same cell is captured would be missed by the RAM read, so that
    // case is flagged and the cell is treated as VISITED.
    // ------------------------------------------------------------------
    logic [c_addr_w-1:0] w_sol_addr;
    logic                w_sol_en;
    logic [1:0]          w_a_q;
    logic                r_p_oe;
    logic                r_p_we;
    logic [c_addr_w-1:0] r_p_addr;
    logic                r_p_fwd;
    logic [1:0]          w_p_code;
    logic                w_commit;
    logic                w_mark_ok;
    logic                w_mark_wall;

    assign w_sol_addr  = cell_addr(row, col);
    assign w_sol_en    = w_in_run & (maze_oe | maze_we);
    assign w_p_code    = r_p_fwd ? c_cell_visited : w_a_q;
    assign w_commit    = r_p_we && (w_p_code == c_cell_free);
    assign w_mark_ok   = r_p_we && (w_p_code != c_cell_wall);
    assign w_mark_wall = r_p_we && (w_p_code == c_cell_wall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_oe   <= 1'b0;
            r_p_we   <= 1'b0;
            r_p_addr <= '0;
            r_p_fwd  <= 1'b0;
        end else begin
            r_p_oe   <= w_in_run & maze_oe;
            r_p_we   <= w_in_run & maze_we;
            r_p_addr <= w_sol_addr;
            r_p_fwd  <= w_commit && (r_p_addr == w_sol_addr);
        end
    end

    // Walls never change after load, so the wall bit taken from the
    // pre-write read is also correct for a same-edge read and mark.
    logic r_maze_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_maze_in <= 1'b1;
        end else if (r_p_oe) begin
            r_maze_in <= (w_p_code == c_cell_wall);
        end
    end

    assign maze_in = r_maze_in;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [STEP_W-1:0] r_steps;
    logic [12:0]       r_visited;
    logic              r_wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_steps   <= '0;
            r_visited <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            if (w_mark_ok && (r_steps != {STEP_W{1'b1}})) begin
                r_steps <= r_steps + 1'b1;
            end
            if (w_commit) begin
                r_visited <= r_visited + 1'b1;
            end
            if (w_mark_wall) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    assign steps   = r_steps;
    assign visited = r_visited;
    assign wr_err  = r_wr_err;

    // ------------------------------------------------------------------
    // RAM write port: loader during LOAD, committed marks afterwards.
    // ------------------------------------------------------------------
    logic                w_ram_we;
    logic [c_addr_w-1:0] w_ram_waddr;
    logic [1:0]          w_ram_wdata;

    always_comb begin
        w_ram_we    = w_load_acc | w_commit;
        w_ram_waddr = r_p_addr;
        w_ram_wdata = c_cell_visited;
        if (w_in_load) begin
            w_ram_waddr = r_load_idx;
            w_ram_wdata = load_data ? c_cell_wall : c_cell_free;
        end
    end

    // ------------------------------------------------------------------
    // Readback. The RAM output register provides the single cycle of
    // latency; rd_cell is gated to zero until a read issued in FINISHED
    // has landed. A mark still committing on the read edge is forwarded.
    // ------------------------------------------------------------------
    logic [c_addr_w-1:0] w_rd_addr;
    logic [1:0]          w_b_q;
    logic                r_rd_valid;
    logic                r_rd_fwd;

    assign w_rd_addr = cell_addr(rd_row, rd_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_fwd   <= 1'b0;
        end else begin
            r_rd_valid <= w_in_fin;
            r_rd_fwd   <= w_commit && (r_p_addr == w_rd_addr);
        end
    end

    assign rd_cell = !r_rd_valid ? c_cell_free :
                     (r_rd_fwd ? c_cell_visited : w_b_q);

    maze_cell_ram #(
        .ADDR_W (c_addr_w),
        .DATA_W (2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_a_en  (w_sol_en),
        .i_a_addr(w_sol_addr),
        .o_a_q   (w_a_q),
        .i_b_addr(w_rd_addr),
        .o_b_q   (w_b_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_maze_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_store
// Description : Self-checking bench for maze_store. Two instances (STEP_W=16
//               and STEP_W=4) share all stimulus; a behavioural maze model
//               predicts cell codes, counters, maze_in and readback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_store;

    localparam int FREE    = 0;
    localparam int WALL    = 1;
    localparam int VISITED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       load_valid;
    logic       load_data;
    logic [5:0] row;
    logic [5:0] col;
    logic       maze_oe;
    logic       maze_we;
    logic       done;
    logic [5:0] rd_row;
    logic [5:0] rd_col;

    logic        load_ready,  load_ready4;
    logic        maze_ready,  maze_ready4;
    logic        maze_in,     maze_in4;
    logic [1:0]  rd_cell,     rd_cell4;
    logic [15:0] steps;
    logic [3:0]  steps4;
    logic [12:0] visited,     visited4;
    logic        wr_err,      wr_err4;

    maze_store #(.STEP_W(16)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .maze_ready(maze_ready), .row(row), .col(col),
        .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in), .done(done),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell), .steps(steps),
        .visited(visited), .wr_err(wr_err)
    );

    maze_store #(.STEP_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready4), .maze_ready(maze_ready4), .row(row), .col(col),
        .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in4), .done(done),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell4), .steps(steps4),
        .visited(visited4), .wr_err(wr_err4)
    );

    // Reference model
    int mcode [4096];
    int m_steps;
    int m_visited;
    int m_err;
    int m_mi;
    int m_fin;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer cells [from, to) with random valid gaps and random solver
    // strobes, which must be ignored while loading.
    task automatic load(input int from, input int to);
        int idx;
        idx = from;
        while (idx < to) begin
            load_valid = ($urandom % 4) != 0;
            load_data  = (mcode[idx] == WALL);
            maze_oe    = $urandom % 2;
            maze_we    = $urandom % 2;
            row        = 6'($urandom);
            col        = 6'($urandom);
            step();
            if (load_valid) idx++;
        end
        load_valid = 1'b0;
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
    endtask

    task automatic issue(input int oe, input int we, input int r, input int c, input int dn);
        int a;
        int pre;
        a   = r * 64 + c;
        pre = mcode[a];
        if (!m_fin) begin
            if (oe != 0) m_mi = (pre == WALL) ? 1 : 0;
            if (we != 0) begin
                if (pre == WALL) begin
                    m_err = 1;
                end else begin
                    if (pre == FREE) begin
                        mcode[a] = VISITED;
                        m_visited++;
                    end
                    m_steps++;
                end
            end
            if (dn != 0) m_fin = 1;
        end
        maze_oe = (oe != 0);
        maze_we = (we != 0);
        done    = (dn != 0);
        row     = 6'(r);
        col     = 6'(c);
        step();
        maze_oe = 1'b0;
        maze_we = 1'b0;
        done    = 1'b0;
    endtask

    task automatic settle(input string tag);
        step();
        step();
        chk({tag, ".maze_in"}, maze_in,  m_mi);
        chk({tag, ".steps"},   steps,    m_steps);
        chk({tag, ".visited"}, visited,  m_visited);
        chk({tag, ".wr_err"},  wr_err,   m_err);
        chk({tag, ".steps4"},  steps4,   (m_steps > 15) ? 15 : m_steps);
    endtask

    task automatic rb(input int r, input int c);
        rd_row = 6'(r);
        rd_col = 6'(c);
        step();
        chk($sformatf("rd_cell(%0d,%0d)", r, c), rd_cell, m_fin ? mcode[r * 64 + c] : 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 1'b0;
        row        = '0;
        col        = '0;
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        done       = 1'b0;
        rd_row     = '0;
        rd_col     = '0;
        m_steps    = 0;
        m_visited  = 0;
        m_err      = 0;
        m_mi       = 1;
        m_fin      = 0;

        // Reset state
        step();
        step();
        chk("rst.load_ready", load_ready, 1);
        chk("rst.maze_ready", maze_ready, 0);
        chk("rst.maze_in",    maze_in,    1);
        chk("rst.rd_cell",    rd_cell,    0);
        chk("rst.steps",      steps,      0);
        chk("rst.visited",    visited,    0);
        chk("rst.wr_err",     wr_err,     0);
        rst = 1'b0;

        // Partial load of a random maze, then asynchronous reset mid-load
        for (int i = 0; i < 4096; i++) mcode[i] = $urandom % 2;
        load(0, 2000);
        chk("partial.load_ready", load_ready, 1);
        chk("partial.maze_ready", maze_ready, 0);
        chk("partial.maze_in",    maze_in,    1);
        rst = 1'b1;
        #1;
        chk("midrst.load_ready", load_ready, 1);
        chk("midrst.maze_ready", maze_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full reload of the real maze
        for (int i = 0; i < 4096; i++) mcode[i] = (($urandom % 8) == 0) ? WALL : FREE;
        mcode[5 * 64 + 7]   = WALL;
        mcode[5 * 64 + 8]   = FREE;
        mcode[3 * 64 + 3]   = FREE;
        mcode[10 * 64 + 10] = FREE;
        mcode[12 * 64 + 12] = FREE;
        mcode[20 * 64 + 20] = FREE;
        load(0, 4095);
        chk("load4095.load_ready", load_ready, 1);
        chk("load4095.maze_ready", maze_ready, 0);
        chk("load4095.maze_in",    maze_in,    1);
        load(4095, 4096);
        chk("loaded.load_ready", load_ready, 0);
        chk("loaded.maze_ready", maze_ready, 1);
        chk("loaded.steps",      steps,      0);
        chk("loaded.wr_err",     wr_err,     0);

        // Directed solver accesses
        issue(1, 0, 5, 7, 0);   settle("oe_wall");
        issue(1, 0, 5, 8, 0);   settle("oe_free");
        issue(1, 1, 3, 3, 0);   settle("oe_we");
        issue(0, 1, 10, 10, 0);
        issue(0, 1, 10, 10, 0); settle("we_twice");
        issue(0, 1, 5, 7, 0);   settle("we_wall");
        for (int i = 0; i < 20; i++) issue(0, 1, 12, 12, 0);
        settle("saturate");
        rb(10, 10);  // not yet finished: reads 0

        // Randomized bursts over a small region to force revisits
        for (int b = 0; b < 60; b++) begin
            int len;
            len = 1 + ($urandom % 4);
            for (int k = 0; k < len; k++) begin
                issue($urandom % 2, $urandom % 2, $urandom % 8, $urandom % 8, 0);
            end
            settle("rand");
        end

        // Done with a same-edge mark, then strobes must be ignored
        issue(0, 1, 20, 20, 1);
        settle("done");
        chk("done.maze_ready", maze_ready, 1);
        chk("done.load_ready", load_ready, 0);
        issue(1, 1, 21, 21, 0);
        issue(1, 1, 5, 7, 0);
        settle("fin_ignore");

        // Readback
        rb(10, 10);
        rb(5, 7);
        rb(3, 3);
        rb(20, 20);
        rb(5, 8);
        rb(12, 12);
        for (int i = 0; i < 20; i++) rb($urandom % 16, $urandom % 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
